// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: per-FU completion FIFOs feed an N-wide registered CDB through a round-robin arbiter.
// Define CDB_BYPASS_EN to let an empty FIFO's live input compete in the same cycle (1-cycle latency).
`ifndef N
`define N 2
`endif
`ifndef PRF_NUM_INDEX_BITS
`define PRF_NUM_INDEX_BITS 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_fu_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         squash,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         nonempty,
  output logic         full,
  output logic [W-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [CW-1:0]           count;

  // Pointers wrap by compare so non-power-of-two depths work.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign nonempty = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign head     = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (squash) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

module cdb_broadcaster #(
  parameter int N          = `N,
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int PRF_IDX    = `PRF_NUM_INDEX_BITS,
  parameter int XLEN       = `XLEN
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 squash,
  input  logic [NUM_FU-1:0]                    fu_valid,
  input  logic [NUM_FU-1:0]                    fu_value_valid,
  input  logic [NUM_FU-1:0][PRF_IDX-1:0]       fu_dest_prf,
  input  logic [NUM_FU-1:0][XLEN-1:0]          fu_value,
  output logic [NUM_FU-1:0]                    fu_ready,
  // slot layout, MSB first: valid, value_valid, dest_prf, value
  output logic [N-1:0][PRF_IDX+XLEN+1:0]       cdb_out
);
  localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic               value_valid;
    logic [PRF_IDX-1:0] dest_prf;
    logic [XLEN-1:0]    value;
  } ent_t;

  typedef struct packed {
    logic valid;
    ent_t ent;
  } cdb_t;

  ent_t [NUM_FU-1:0]      fu_ent, head, cand;
  logic [NUM_FU-1:0]      nonempty, full, req, gnt, push, pop;
  logic                   alive;
  logic [FW-1:0]          ptr, ptr_nxt;
  logic [N-1:0]           slot_vld;
  logic [N-1:0][FW-1:0]   slot_fu;
  cdb_t [N-1:0]           cdb_nxt;

  // alive keeps fu_ready low until the first edge after reset release.
  assign fu_ready = {NUM_FU{alive}} & ~full;

  generate
    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
      assign fu_ent[i] = {fu_value_valid[i], fu_dest_prf[i], fu_value[i]};
`ifdef CDB_BYPASS_EN
      assign req[i]  = nonempty[i] | (fu_valid[i] & fu_ready[i]);
      assign cand[i] = nonempty[i] ? head[i] : fu_ent[i];
      assign push[i] = fu_valid[i] & fu_ready[i] & ~(gnt[i] & ~nonempty[i]);
`else
      assign req[i]  = nonempty[i];
      assign cand[i] = head[i];
      assign push[i] = fu_valid[i] & fu_ready[i];
`endif
      assign pop[i] = gnt[i] & nonempty[i];

      cdb_fu_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(ent_t))) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .push      (push[i]),
        .push_data (fu_ent[i]),
        .pop       (pop[i]),
        .nonempty  (nonempty[i]),
        .full      (full[i]),
        .head      (head[i])
      );
    end
  endgenerate

  // Scan from ptr, granting the first N requesters into slots 0..N-1 in order.
  always_comb begin
    int taken;
    int idx;
    taken    = 0;
    idx      = 0;
    gnt      = '0;
    slot_vld = '0;
    slot_fu  = '0;
    ptr_nxt  = ptr;
    for (int j = 0; j < NUM_FU; j++) begin
      idx = int'(ptr) + j;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      for (int f = 0; f < NUM_FU; f++) begin
        if (f == idx && req[f] && taken < N) begin
          gnt[f] = 1'b1;
          for (int k = 0; k < N; k++) begin
            if (k == taken) begin
              slot_vld[k] = 1'b1;
              slot_fu[k]  = FW'(f);
            end
          end
          ptr_nxt = (f == NUM_FU - 1) ? '0 : FW'(f + 1);
          taken   = taken + 1;
        end
      end
    end
  end

  always_comb begin
    cdb_nxt = '0;
    for (int k = 0; k < N; k++)
      if (slot_vld[k]) cdb_nxt[k] = {1'b1, cand[slot_fu[k]]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alive   <= 1'b0;
      ptr     <= '0;
      cdb_out <= '0;
    end else if (squash) begin
      alive   <= 1'b1;
      ptr     <= '0;
      cdb_out <= '0;
    end else begin
      alive   <= 1'b1;
      ptr     <= ptr_nxt;
      cdb_out <= cdb_nxt;
    end
  end
endmodule
